// File: rtl/hex_seg_pkg.sv
// Shared constants for the HEX0 seven-segment driver: PIO byte field layout and
// the active-high gfedcba digit table.
package hex_seg_pkg;

    localparam int DIGIT_LSB = 0;
    localparam int DP_BIT    = 4;
    localparam int BLANK_BIT = 5;
    localparam int BLINK_BIT = 6;

    // Out of reset the register holds "blank" so nothing lights before the PIO is written
    localparam logic [7:0] DATA_RESET = 8'h20;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/hex_seg_blink_timer.sv
// Blink half-period timer: prescaler counts 0..DIV-1, phase toggles on each wrap.
// Held at 0/0 while not running; restart clears it and takes priority over a wrap.
module hex_seg_blink_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_restart,
    output logic o_phase
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_prescaler;
    logic          r_phase;
    logic          w_wrap;

    assign w_wrap  = i_run && (r_prescaler == LAST);
    assign o_phase = r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescaler <= '0;
            r_phase     <= 1'b0;
        end else if (i_restart || !i_run) begin
            r_prescaler <= '0;
            r_phase     <= 1'b0;
        end else if (w_wrap) begin
            r_prescaler <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

endmodule

// File: rtl/hex_seg_driver.sv
// HEX0 seven-segment driver: registers the PIO byte, decodes the digit and applies dp/blank/blink.
// Optional macro HEX_SEG_UPDATE_FLASH_EN flashes dp for DIV-1 cycles whenever the digit changes.
module hex_seg_driver
    import hex_seg_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BLINK_HZ    = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pio_data,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [6:0] SEG_OFF_PIN = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic       DP_OFF_PIN  = 1'(ACTIVE_LOW != 0);

    logic [7:0] r_dataQ;
    logic       w_phase;
    logic       w_restart;
    logic       w_flash;
    logic [6:0] w_segAh;
    logic       w_dpAh;
    logic       w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dataQ <= DATA_RESET;
        end else begin
            r_dataQ <= pio_data;
        end
    end

    // Asserted on the edge where r_dataQ's blink bit is about to rise, so the timer starts visible
    assign w_restart = pio_data[BLINK_BIT] & ~r_dataQ[BLINK_BIT];

    hex_seg_blink_timer #(
        .DIV(DIV)
    ) u_blinkTimer (
        .clk      (clk),
        .reset    (reset),
        .i_run    (r_dataQ[BLINK_BIT]),
        .i_restart(w_restart),
        .o_phase  (w_phase)
    );

`ifdef HEX_SEG_UPDATE_FLASH_EN
    localparam logic [CW-1:0] FLASH_LOAD = CW'(DIV - 1);

    logic [CW-1:0] r_flashCnt;
    logic          r_primed;

    // r_primed masks the first load of r_dataQ after reset so the reset value never counts as a change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flashCnt <= '0;
            r_primed   <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            if (r_primed && (pio_data[DIGIT_LSB +: 4] != r_dataQ[DIGIT_LSB +: 4])) begin
                r_flashCnt <= FLASH_LOAD;
            end else if (r_flashCnt != '0) begin
                r_flashCnt <= r_flashCnt - 1'b1;
            end
        end
    end

    assign w_flash = (r_flashCnt != '0);
`else
    assign w_flash = 1'b0;
`endif

    always_comb begin
        w_segAh = segDecode(r_dataQ[DIGIT_LSB +: 4]);
        w_dpAh  = r_dataQ[DP_BIT] | w_flash;
        if (r_dataQ[BLANK_BIT] || (r_dataQ[BLINK_BIT] && w_phase)) begin
            w_segAh = SEG_OFF;
            w_dpAh  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF_PIN;
            dp  <= DP_OFF_PIN;
        end else if (ACTIVE_LOW != 0) begin
            seg <= ~w_segAh;
            dp  <= ~w_dpAh;
        end else begin
            seg <= w_segAh;
            dp  <= w_dpAh;
        end
    end

    assign w_unused = r_dataQ[7];

endmodule

// File: tb/tb_hex_seg_driver.sv
// Scoreboard bench for hex_seg_driver at DIV=4, low-true pins; expectations are queued
// per clock cycle by the stimulus and checked by an independent monitor.
module tb_hex_seg_driver;

`ifdef HEX_SEG_UPDATE_FLASH_EN
    localparam logic FLASH_DP = 1'b0;
`else
    localparam logic FLASH_DP = 1'b1;
`endif

    typedef struct packed {
        int         cyc;
        int         tag;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] pio_data;
    logic [6:0] seg;
    logic       dp;

    exp_t sb[$];
    int   cyc;
    int   driveCyc;
    int   compared;
    int   mismatched;

    logic [6:0] sweepExp [16];

    hex_seg_driver #(
        .CLK_FREQ_HZ(8),
        .BLINK_HZ   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pio_data(pio_data),
        .seg     (seg),
        .dp      (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input int tag, input logic [6:0] expSeg, input logic expDp);
        compared++;
        if (seg !== expSeg || dp !== expDp) begin
            mismatched++;
            $display("[TB] FAIL step%0d cyc=%0d: got seg=%02h dp=%b, want seg=%02h dp=%b",
                     tag, cyc, seg, dp, expSeg, expDp);
        end
    endtask

    // Monitor: every cycle, compare any expectations targeted at this cycle
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    checkOutput(sb[i].tag, sb[i].seg, sb[i].dp);
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL step%0d stale expectation for cyc=%0d", sb[i].tag, sb[i].cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        pio_data = d;
        driveCyc = cyc;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset    = 1'b0;
        driveCyc = cyc;
    endtask

    task automatic expectAt(input int lag, input logic [6:0] s, input logic d, input int tag);
        exp_t e;
        e.cyc = driveCyc + lag;
        e.tag = tag;
        e.seg = s;
        e.dp  = d;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        driveCyc   = 0;
        reset      = 1'b1;
        pio_data   = 8'h00;
        sweepExp   = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset state, then idle digit 0
        idle(2);
        checkOutput(0, 7'h7F, 1'b1);
        releaseReset();
        expectAt(1, 7'h7F, 1'b1, 1);
        expectAt(2, 7'h40, 1'b1, 1);

        // Decode sweep
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i));
            expectAt(2, sweepExp[i], (i == 0) ? 1'b1 : FLASH_DP, 2);
        end

        // Blink: 4 visible, 4 dark, 4 visible, then dark
        applyStimulus(8'h41);
        for (int l = 2; l <= 4; l++) expectAt(l, 7'h79, FLASH_DP, 3);
        expectAt(5, 7'h79, 1'b1, 3);
        for (int l = 6; l <= 9; l++) expectAt(l, 7'h7F, 1'b1, 3);
        for (int l = 10; l <= 13; l++) expectAt(l, 7'h79, 1'b1, 3);
        expectAt(14, 7'h7F, 1'b1, 3);
        idle(13);
        applyStimulus(8'h01);
        expectAt(1, 7'h7F, 1'b1, 4);
        expectAt(2, 7'h79, 1'b1, 4);

        // Blank overrides blink, dp and any flash
        applyStimulus(8'h68);
        for (int l = 2; l <= 6; l++) expectAt(l, 7'h7F, 1'b1, 5);
        idle(4);
        applyStimulus(8'h18);
        expectAt(2, 7'h00, 1'b0, 6);
        expectAt(3, 7'h00, 1'b0, 6);
        idle(3);

        // Asynchronous reset while digit is lit
        reset = 1'b1;
        #1;
        checkOutput(7, 7'h7F, 1'b1);
        idle(2);
        releaseReset();
        expectAt(1, 7'h7F, 1'b1, 8);
        expectAt(2, 7'h00, 1'b0, 8);

        // Reset during the dark phase, then a full visible phase after release
        applyStimulus(8'h41);
        for (int l = 2; l <= 4; l++) expectAt(l, 7'h79, FLASH_DP, 9);
        expectAt(5, 7'h79, 1'b1, 9);
        expectAt(6, 7'h7F, 1'b1, 9);
        idle(6);
        reset = 1'b1;
        #1;
        checkOutput(10, 7'h7F, 1'b1);
        idle(2);
        releaseReset();
        expectAt(1, 7'h7F, 1'b1, 11);
        for (int l = 2; l <= 5; l++) expectAt(l, 7'h79, 1'b1, 11);
        expectAt(6, 7'h7F, 1'b1, 11);
        idle(4);

        // Digit-change dp flash, and extension by a second change mid-flash
        applyStimulus(8'h03);
        for (int l = 2; l <= 4; l++) expectAt(l, 7'h30, FLASH_DP, 12);
        expectAt(5, 7'h30, 1'b1, 12);
        idle(4);
        applyStimulus(8'h05);
        expectAt(2, 7'h12, FLASH_DP, 13);
        applyStimulus(8'h07);
        for (int l = 2; l <= 4; l++) expectAt(l, 7'h78, FLASH_DP, 13);
        expectAt(5, 7'h78, 1'b1, 13);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        while (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL step%0d expectation for cyc=%0d never checked", sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
